mcs51_serial_peer: RTL

Board-side serial partner for the MCU's UART: receives frames the MCU shifts out on TXD (P3.1) and transmits frames into the MCU's RXD (P3.0). Supports 8-bit (mode 1 framing) and 9-bit (mode 2/3 framing) asynchronous frames at a fixed bit period, with a valid/ready byte interface toward a host, a bench driver or a bridge. Sits outside `mcs51_mcu` at top level or in the testbench: `rxd_in` is tied to `p3_out[1]` and `txd_out` to `p3_in[0]`.

---
 rtl/mcs51_serial_peer.sv | 289 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/mcs51_serial_peer.sv
// Serial partner for the MCU UART: RX from TXD, TX into RXD, 8- or 9-bit async frames.
// Define MCS51_SERIAL_PEER_RXFIFO_EN for an RX_FIFO_DEPTH-entry receive FIFO (default: one holding register).
//
// state   | meaning (shared by the RX and TX machines)
// S_IDLE  | line idle; RX waits for a falling edge, TX offers tx_ready
// S_START | start bit (RX: counting to mid-bit for validation)
// S_DATA  | 8 data bits, LSB first
// S_BIT9  | optional 9th bit
// S_STOP  | stop bit (RX: also waits for line high after a framing error)
module mcs51_serial_peer #(
    parameter int CLKS_PER_BIT  = 32,
    parameter int RX_FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       nine_bit,
    input  logic       rxd_in,
    output logic       txd_out,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic [7:0] tx_data,
    input  logic       tx_bit9,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic [7:0] rx_data,
    output logic       rx_bit9,
    output logic       rx_frame_err,
    output logic       rx_overrun
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_BIT9, S_STOP} state_t;

    // ---------------- RX input synchronizer ----------------
    logic rx_meta, rxs, rxs_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            rxs_d   <= 1'b1;
        end else begin
            rx_meta <= rxd_in;
            rxs     <= rx_meta;
            rxs_d   <= rxs;
        end
    end

    // ---------------- RX state machine ----------------
    state_t          rx_state;
    logic [CW-1:0]   rx_cnt;
    logic [2:0]      rx_idx;
    logic [7:0]      rx_sh;
    logic            rx_b9;
    logic            rx_nine;
    logic            rx_err_wait;
    logic            rx_tc;
    logic            rx_push;
    logic            rx_pop;

    assign rx_tc   = (rx_cnt == '0);
    assign rx_push = (rx_state == S_STOP) && !rx_err_wait && rx_tc && rxs;
    assign rx_pop  = rx_valid && rx_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_state     <= S_IDLE;
            rx_cnt       <= '0;
            rx_idx       <= '0;
            rx_sh        <= '0;
            rx_b9        <= 1'b0;
            rx_nine      <= 1'b0;
            rx_err_wait  <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            rx_frame_err <= 1'b0;
            case (rx_state)
                S_IDLE: begin
                    if (rxs_d && !rxs) begin
                        rx_cnt   <= HALF_LAST;
                        rx_nine  <= nine_bit;
                        rx_state <= S_START;
                    end
                end
                S_START: begin
                    if (rx_tc) begin
                        if (!rxs) begin
                            rx_cnt   <= BIT_LAST;
                            rx_idx   <= '0;
                            rx_b9    <= 1'b0;
                            rx_state <= S_DATA;
                        end else begin
                            rx_state <= S_IDLE;
                        end
                    end else begin
                        rx_cnt <= rx_cnt - CNT_ONE;
                    end
                end
                S_DATA: begin
                    if (rx_tc) begin
                        rx_sh  <= {rxs, rx_sh[7:1]};
                        rx_cnt <= BIT_LAST;
                        rx_idx <= rx_idx + 3'd1;
                        if (rx_idx == 3'd7)
                            rx_state <= rx_nine ? S_BIT9 : S_STOP;
                    end else begin
                        rx_cnt <= rx_cnt - CNT_ONE;
                    end
                end
                S_BIT9: begin
                    if (rx_tc) begin
                        rx_b9    <= rxs;
                        rx_cnt   <= BIT_LAST;
                        rx_state <= S_STOP;
                    end else begin
                        rx_cnt <= rx_cnt - CNT_ONE;
                    end
                end
                S_STOP: begin
                    // after a low stop bit, hold here until the line returns high
                    if (rx_err_wait) begin
                        if (rxs) begin
                            rx_err_wait <= 1'b0;
                            rx_state    <= S_IDLE;
                        end
                    end else if (rx_tc) begin
                        if (rxs) begin
                            rx_state <= S_IDLE;
                        end else begin
                            rx_frame_err <= 1'b1;
                            rx_err_wait  <= 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt - CNT_ONE;
                    end
                end
                default: rx_state <= S_IDLE;
            endcase
        end
    end

    // ---------------- RX buffer ----------------
`ifdef MCS51_SERIAL_PEER_RXFIFO_EN
    localparam int AW = $clog2(RX_FIFO_DEPTH);

    logic [8:0]  fifo_mem [RX_FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   fifo_cnt;
    logic          fifo_full;
    logic          do_push;

    assign fifo_full = (fifo_cnt == (AW+1)'(RX_FIFO_DEPTH));
    // a pop frees a slot in the same cycle, so a full FIFO with a pop still accepts
    assign do_push   = rx_push && (!fifo_full || rx_pop);
    assign rx_valid  = (fifo_cnt != '0);
    assign rx_data   = fifo_mem[rd_ptr][7:0];
    assign rx_bit9   = fifo_mem[rd_ptr][8];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < RX_FIFO_DEPTH; i++) fifo_mem[i] <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_cnt   <= '0;
            rx_overrun <= 1'b0;
        end else begin
            rx_overrun <= rx_push && fifo_full && !rx_pop;
            if (do_push) begin
                fifo_mem[wr_ptr] <= {rx_b9, rx_sh};
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rx_pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, rx_pop})
                2'b10:   fifo_cnt <= fifo_cnt + (AW+1)'(1);
                2'b01:   fifo_cnt <= fifo_cnt - (AW+1)'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end
`else
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_valid   <= 1'b0;
            rx_data    <= '0;
            rx_bit9    <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            rx_overrun <= 1'b0;
            if (rx_push && rx_valid && !rx_pop) begin
                rx_overrun <= 1'b1;
            end else if (rx_push) begin
                rx_valid <= 1'b1;
                rx_data  <= rx_sh;
                rx_bit9  <= rx_b9;
            end else if (rx_pop) begin
                rx_valid <= 1'b0;
            end
        end
    end
`endif

    // ---------------- TX state machine ----------------
    state_t        tx_state;
    logic [CW-1:0] tx_cnt;
    logic [2:0]    tx_idx;
    logic [7:0]    tx_sh;
    logic          tx_b9;
    logic          tx_nine;
    logic          tx_tc;

    assign tx_tc = (tx_cnt == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_state <= S_IDLE;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_sh    <= '0;
            tx_b9    <= 1'b0;
            tx_nine  <= 1'b0;
            txd_out  <= 1'b1;
            tx_ready <= 1'b1;
        end else begin
            case (tx_state)
                S_IDLE: begin
                    if (tx_valid && tx_ready) begin
                        tx_sh    <= tx_data;
                        tx_b9    <= tx_bit9;
                        tx_nine  <= nine_bit;
                        txd_out  <= 1'b0;
                        tx_cnt   <= BIT_LAST;
                        tx_ready <= 1'b0;
                        tx_state <= S_START;
                    end
                end
                S_START: begin
                    if (tx_tc) begin
                        txd_out  <= tx_sh[0];
                        tx_sh    <= {1'b0, tx_sh[7:1]};
                        tx_idx   <= '0;
                        tx_cnt   <= BIT_LAST;
                        tx_state <= S_DATA;
                    end else begin
                        tx_cnt <= tx_cnt - CNT_ONE;
                    end
                end
                S_DATA: begin
                    if (tx_tc) begin
                        tx_cnt <= BIT_LAST;
                        if (tx_idx == 3'd7) begin
                            txd_out  <= tx_nine ? tx_b9 : 1'b1;
                            tx_state <= tx_nine ? S_BIT9 : S_STOP;
                        end else begin
                            txd_out <= tx_sh[0];
                            tx_sh   <= {1'b0, tx_sh[7:1]};
                            tx_idx  <= tx_idx + 3'd1;
                        end
                    end else begin
                        tx_cnt <= tx_cnt - CNT_ONE;
                    end
                end
                S_BIT9: begin
                    if (tx_tc) begin
                        txd_out  <= 1'b1;
                        tx_cnt   <= BIT_LAST;
                        tx_state <= S_STOP;
                    end else begin
                        tx_cnt <= tx_cnt - CNT_ONE;
                    end
                end
                S_STOP: begin
                    if (tx_tc) begin
                        tx_ready <= 1'b1;
                        tx_state <= S_IDLE;
                    end else begin
                        tx_cnt <= tx_cnt - CNT_ONE;
                    end
                end
                default: tx_state <= S_IDLE;
            endcase
        end
    end

endmodule
